// File: rtl/vga_pkg.sv
// Shared types for the SPI command sequencer: opcodes, FSM states and the
// 24-bit command record that travels through the command FIFO.
package vga_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_WRITE_CELL = 3'b001,
        OP_CLEAR      = 3'b010,
        OP_SET_SCORE  = 3'b011,
        OP_SET_STATE  = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [7:0] command;
        logic [7:0] databyte1;
        logic [7:0] databyte2;
    } cmd_rec_t;

    localparam int CMD_W = $bits(cmd_rec_t);

    // Undefined opcodes (101..111) collapse to NOP.
    function automatic opcode_e decode_op(input logic [7:0] cmd);
        case (cmd[7:5])
            3'b001:  return OP_WRITE_CELL;
            3'b010:  return OP_CLEAR;
            3'b011:  return OP_SET_SCORE;
            3'b100:  return OP_SET_STATE;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// A push while full is dropped even if a pop happens in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/cmd_sequencer.sv
// Buffers SPI commands and executes them: cell writes, full-framebuffer clear,
// score and game-state updates. All outputs are registered except busy.
module cmd_sequencer
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        command,
    input  logic [7:0]        databyte1,
    input  logic [7:0]        databyte2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [9:0]        score,
    output logic [15:0]       state,
    output logic              busy,
    output logic              overflow,
    output logic [1:0]        o_fsm_state
);
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    fsm_e              r_fsm;
    cmd_rec_t          r_cur;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [9:0]        r_score;
    logic [15:0]       r_game_state;
    logic              r_overflow;

    cmd_rec_t          w_in;
    cmd_rec_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_in   = '{command: command, databyte1: databyte1, databyte2: databyte2};
    assign w_push = cmd_valid && !reset;
    assign w_pop  = (r_fsm == ST_IDLE) && !w_empty;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_overflow <= 1'b0;
        else if (cmd_valid && w_full) r_overflow <= 1'b1;
    end

    // A WRITE_CELL's strobe is launched on the pop edge so it lands in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= ST_IDLE;
            r_cur        <= '0;
            r_clr_cnt    <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_score      <= '0;
            r_game_state <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    r_we <= 1'b0;
                    if (!w_empty) begin
                        r_cur <= w_head;
                        r_fsm <= ST_EXEC;
                        if (decode_op(w_head.command) == OP_WRITE_CELL) begin
                            r_we    <= 1'b1;
                            r_waddr <= ADDR_W'({w_head.command[1:0], w_head.databyte1});
                            r_wdata <= DATA_W'(w_head.databyte2);
                        end
                    end
                end
                ST_EXEC: begin
                    r_we  <= 1'b0;
                    r_fsm <= ST_IDLE;
                    case (decode_op(r_cur.command))
                        OP_SET_SCORE: r_score      <= {r_cur.databyte1[1:0], r_cur.databyte2};
                        OP_SET_STATE: r_game_state <= {r_cur.databyte1, r_cur.databyte2};
                        OP_CLEAR: begin
                            r_fsm     <= ST_CLEAR;
                            r_clr_cnt <= '0;
                            r_we      <= 1'b1;
                            r_waddr   <= '0;
                            r_wdata   <= DATA_W'(r_cur.databyte2);
                        end
                        default: ;
                    endcase
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == CNT_LAST) begin
                        r_we      <= 1'b0;
                        r_clr_cnt <= '0;
                        r_fsm     <= ST_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CNT_ONE;
                        r_waddr   <= r_clr_cnt + CNT_ONE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign we          = r_we;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign score       = r_score;
    assign state       = r_game_state;
    assign overflow    = r_overflow;
    assign busy        = (r_fsm != ST_IDLE) || !w_empty;
    assign o_fsm_state = r_fsm;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: vector table for single commands, scoreboard of
// expected framebuffer writes, and hand sequences for clear/overflow/reset.
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  command;
    logic [7:0]  databyte1;
    logic [7:0]  databyte2;
    logic        we;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic [9:0]  score;
    logic [15:0] state;
    logic        busy;
    logic        overflow;
    logic [1:0]  o_fsm_state;

    always #5 clk = ~clk;

    cmd_sequencer #(.FIFO_DEPTH(4), .ADDR_W(10), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .command     (command),
        .databyte1   (databyte1),
        .databyte2   (databyte2),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .score       (score),
        .state       (state),
        .busy        (busy),
        .overflow    (overflow),
        .o_fsm_state (o_fsm_state)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          first_we = -1;
    int          last_we = -1;
    logic        rec_en = 1'b0;
    int          we_cyc_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  db1;
        logic [7:0]  db2;
        logic        wr;
        logic [9:0]  exp_score;
        logic [15:0] exp_state;
    } vec_t;
    vec_t vecs[12];

    // Write monitor: every we cycle must match the head of the expected queue.
    always @(negedge clk) begin
        cyc++;
        if (we) begin
            we_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (rec_en) we_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual waddr=%h wdata=%h required no write", waddr, wdata);
            end else begin
                exp_v = exp_q.pop_front();
                if ({waddr, wdata} !== exp_v) begin
                    errors++;
                    $display("FAIL write_data actual=%h/%h required=%h/%h",
                             waddr, wdata, exp_v[17:8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_write(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({c[1:0], b1, b2});
    endtask

    task automatic drive(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        command   = c;
        databyte1 = b1;
        databyte2 = b2;
    endtask

    task automatic release_valid();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        drive(c, b1, b2);
        release_valid();
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || we) && n < max_cycles);
        if (busy || we) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual busy=%b required busy=0 within %0d cycles", name, busy, max_cycles);
        end
    endtask

    // Commands offered while reset is high must be ignored.
    task automatic reset_dut();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        command   = 8'h21;
        databyte1 = 8'h34;
        databyte2 = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {22'd0, waddr}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_score", {22'd0, score}, 32'd0);
        check("rst_state", {16'd0, state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_fsm", {30'd0, o_fsm_state}, 32'd0);
    endtask

    task automatic latency_test();
        exp_write(8'h21, 8'h34, 8'h5A);
        issue(8'h21, 8'h34, 8'h5A);
        @(negedge clk);
        check("lat_n1_we", {31'd0, we}, 32'd0);
        @(negedge clk);
        check("lat_n2_we", {31'd0, we}, 32'd1);
        check("lat_n2_waddr", {22'd0, waddr}, 32'h134);
        check("lat_n2_wdata", {24'd0, wdata}, 32'h5A);
        @(negedge clk);
        check("lat_n3_we", {31'd0, we}, 32'd0);
        wait_idle(10, "lat");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=no finish required=finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h21, 8'h34, 8'h5A, 1'b1, 10'h000, 16'h0000};
        vecs[1]  = '{8'h60, 8'h03, 8'hE7, 1'b0, 10'h3E7, 16'h0000};
        vecs[2]  = '{8'h80, 8'h12, 8'h34, 1'b0, 10'h3E7, 16'h1234};
        vecs[3]  = '{8'hE0, 8'hFF, 8'hFF, 1'b0, 10'h3E7, 16'h1234};
        vecs[4]  = '{8'h23, 8'hFF, 8'hA5, 1'b1, 10'h3E7, 16'h1234};
        vecs[5]  = '{8'h7C, 8'hFE, 8'h01, 1'b0, 10'h201, 16'h1234};
        vecs[6]  = '{8'h00, 8'h55, 8'h66, 1'b0, 10'h201, 16'h1234};
        vecs[7]  = '{8'h20, 8'h00, 8'h11, 1'b1, 10'h201, 16'h1234};
        vecs[8]  = '{8'hA0, 8'h77, 8'h88, 1'b0, 10'h201, 16'h1234};
        vecs[9]  = '{8'h9F, 8'hAB, 8'hCD, 1'b0, 10'h201, 16'hABCD};
        vecs[10] = '{8'hC3, 8'h12, 8'h34, 1'b0, 10'h201, 16'hABCD};
        vecs[11] = '{8'h3F, 8'h80, 8'h00, 1'b1, 10'h201, 16'hABCD};

        reset_dut();
        latency_test();

        foreach (vecs[i]) begin
            if (vecs[i].wr) exp_write(vecs[i].cmd, vecs[i].db1, vecs[i].db2);
            issue(vecs[i].cmd, vecs[i].db1, vecs[i].db2);
            wait_idle(20, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_score", i), {22'd0, score}, {22'd0, vecs[i].exp_score});
            check($sformatf("vec%0d_state", i), {16'd0, state}, {16'd0, vecs[i].exp_state});
        end

        // Back-to-back WRITE_CELLs: one write every two cycles.
        we_cyc_q.delete();
        rec_en = 1'b1;
        for (int k = 0; k < 3; k++) exp_write(8'h22, 8'(k * 16), 8'(8'hC0 + k));
        for (int k = 0; k < 3; k++) drive(8'h22, 8'(k * 16), 8'(8'hC0 + k));
        release_valid();
        wait_idle(20, "b2b");
        rec_en = 1'b0;
        check("b2b_count", we_cyc_q.size(), 32'd3);
        if (we_cyc_q.size() == 3) begin
            check("b2b_gap0", we_cyc_q[1] - we_cyc_q[0], 32'd2);
            check("b2b_gap1", we_cyc_q[2] - we_cyc_q[1], 32'd2);
        end

        // NOP: busy through pop and EXEC, clear afterwards.
        issue(8'hE0, 8'h00, 8'h00);
        @(negedge clk);
        check("nop_busy_n1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("nop_busy_n2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("nop_busy_n3", {31'd0, busy}, 32'd0);
        check("nop_score", {22'd0, score}, 32'h201);
        check("nop_state", {16'd0, state}, 32'hABCD);

        // Full clear sweep.
        we_cnt = 0;
        first_we = -1;
        for (int a = 0; a < 1024; a++) exp_q.push_back({a[9:0], 8'h07});
        issue(8'h40, 8'h00, 8'h07);
        wait_idle(1100, "clear");
        check("clear_we_count", we_cnt, 32'd1024);
        check("clear_contiguous", last_we - first_we + 1, 32'd1024);
        check("clear_queue_drained", exp_q.size(), 32'd0);
        check("clear_busy", {31'd0, busy}, 32'd0);
        check("clear_fsm_idle", {30'd0, o_fsm_state}, 32'd0);

        // Four writes buffered during a sweep; the fifth overflows.
        for (int a = 0; a < 1024; a++) exp_q.push_back({a[9:0], 8'h00});
        issue(8'h40, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        check("ovf_in_clear", {30'd0, o_fsm_state}, 32'd2);
        check("ovf_before", {31'd0, overflow}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            exp_write(8'h21, 8'(8'h10 + k), 8'(8'h90 + k));
            issue(8'h21, 8'(8'h10 + k), 8'(8'h90 + k));
        end
        issue(8'h21, 8'hEE, 8'hEE);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        wait_idle(1200, "ovf");
        check("ovf_queue_drained", exp_q.size(), 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of a sweep.
        reset_dut();
        for (int a = 0; a < 1024; a++) exp_q.push_back({a[9:0], 8'h33});
        issue(8'h40, 8'h00, 8'h33);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(we && waddr == 10'd500) && n < 700);
            check("abort_reached_500", {22'd0, waddr}, 32'd500);
        end
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_waddr", {22'd0, waddr}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        latency_test();

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
